lift_scheduler: RTL and testbench
=================================

# lift_scheduler

Floor-request scheduler and motion/door sequencer for the SmartLift elevator. It latches floor requests from the `sw` switches into a pending set and serves them with SCAN (elevator) ordering. It steps the car one floor per travel interval and holds the doors open for a fixed interval at each served floor. It drives the door LEDs directly and exports the current floor, target floor and direction to the HEX display decoders.

## Interface
- `FLOORS`, 9: number of floors, numbered 0..FLOORS-1; legal range 2..16.
- `MOVE_CYCLES`, 50_000_000: clock cycles to travel one floor; must be ≥ 2.
- `DOOR_CYCLES`, 100_000_000: clock cycles the doors stay open; must be ≥ 2.
- `IDLE_CYCLES`, 250_000_000: idle time before return-to-ground; used only with `LIFT_IDLE_RETURN_EN`.
- `clk` input 1: single system clock; all state changes on its rising edge.
- `res` input 1: asynchronous, active-low reset.
- `sw` input FLOORS: floor request switches; bit i requests floor i.
- `LED_RED` output 4: doors closed indicator; all 4 bits equal.
- `LED_GREEN` output 4: doors open indicator; all 4 bits equal.
- `floor` output 4: current floor (feeds HEX0 decoder).
- `next_floor` output 4: floor currently being travelled to; 4'hF when there is none.
- `dir` output 2: 2'b01 up, 2'b10 down, 2'b00 stopped (feeds HEX1 decoder).
- `pending` output FLOORS: outstanding request set.

## Operation
- **Reset values** (while `res` = 0):
  - state IDLE, `floor` = 0, `pending` = 0, `dir` = 00.
  - last-direction preference = up.
  - `LED_RED` = 4'hF, `LED_GREEN` = 0, `next_floor` = 4'hF.
  - switch register `sw_q` = 0.
- **Request capture:**
  - `sw_q` registers `sw` every cycle; rise = `sw & ~sw_q`.
  - A rise on bit i sets `pending[i]`.
  - Exception: a rise for the current floor while in DOOR_OPEN does not set `pending`; it restarts the door timer instead.
  - A switch already high at reset release counts as a rise on the first clock.
  - Held switches do not re-request.
- **States:** IDLE, MOVING, DOOR_OPEN.
- **IDLE** (`dir` = 00, doors closed):
  - If `pending[floor]` is set: clear it and go to DOOR_OPEN.
  - Else, if requests exist in the preferred direction: go to MOVING that way.
  - Else, if requests exist in the opposite direction: flip the preference and go to MOVING.
  - Else: stay in IDLE.
  - On entry to MOVING, the timer loads MOVE_CYCLES-1.
- **MOVING** (doors closed, `dir` = preference):
  - The timer decrements each cycle.
  - In the cycle where the timer is 0, `floor` steps ±1 at the clock edge.
  - Next state on that edge:
    - If the new floor is pending: clear the bit and go to DOOR_OPEN.
    - Else, if requests remain further in the current direction: stay in MOVING and reload the timer.
    - Else: go to IDLE.
  - `floor` never leaves 0..FLOORS-1.
- **DOOR_OPEN** (`LED_GREEN` = 4'hF, `LED_RED` = 0, `dir` = 00):
  - The timer loads DOOR_CYCLES-1 on entry and decrements each cycle.
  - At 0, go to IDLE.
  - A same-floor rise reloads DOOR_CYCLES-1.
- **`next_floor`:** the nearest pending floor in the current direction while MOVING; 4'hF otherwise.
- **Reset mid-operation:** asynchronous return to the reset values; all pending requests are lost.
- **Simultaneous events:** a rise on the floor being arrived at in the same cycle is served by that arrival; no duplicate stop.

## Timing
- Switch rise to `pending` set: 1 cycle (visible after the edge that samples the rise).
- IDLE decision: 1 cycle after `pending` becomes visible.
- Floor step: exactly MOVE_CYCLES cycles after entering MOVING, and then every MOVE_CYCLES cycles thereafter.
- Door open time: exactly DOOR_CYCLES cycles, absent restarts.
- Return to IDLE: takes 1 cycle; the next move starts 1 cycle after that.
- All outputs are registered; there are no combinational paths from `sw`.

## Configuration
- **`LIFT_IDLE_RETURN_EN` defined:**
  - An idle counter runs while state = IDLE, `pending` = 0 and `floor` ≠ 0.
  - The counter clears on any other condition.
  - When it reaches IDLE_CYCLES, `pending[0]` is set and the car returns to ground by the normal path.
- **Not defined:** the counter logic is absent and the car parks wherever it last stopped.

## Test plan
Bench parameters: FLOORS=9, MOVE_CYCLES=4, DOOR_CYCLES=3, IDLE_CYCLES=10.
- Reset, then raise `sw[3]` → `pending` = 9'h008 after 1 cycle. `dir` = 01; `floor` reads 1, 2, 3 at 4-cycle intervals. Doors green for 3 cycles, then red, `dir` = 00, `pending` = 0.
- At floor 3 moving up to floor 7, raise `sw[5]` and `sw[1]` → stops at 5 then 7, then reverses (`dir` = 10) and stops at 1.
- During DOOR_OPEN at floor 5, toggle `sw[5]` 0→1 → door period extended to 3 cycles from the rise; `pending[5]` stays 0.
- Assert `res` low mid-MOVING between floors 2 and 3 → outputs immediately at reset values; after release with no switches high, the car stays in IDLE at floor 0.
- Hold `sw[0]` high through reset release → request served at floor 0: door opens with no movement.
- With `LIFT_IDLE_RETURN_EN`, park at floor 4 → after 10 idle cycles `pending[0]` is set and the car descends to 0. Without the macro, the car stays at floor 4 indefinitely.

Source files
------------

// File: rtl/lift_scheduler.sv
// lift_scheduler: SCAN-ordered floor request scheduler and motion/door sequencer
// for the SmartLift car. Rising edges on sw[] latch into a pending set; the car
// steps one floor every MOVE_CYCLES and holds its doors open for DOOR_CYCLES.
// Optional feature macro: LIFT_IDLE_RETURN_EN. When it is defined, a car that
// sits idle away from ground for IDLE_CYCLES requests floor 0 by itself.
module lift_scheduler #(
  parameter int FLOORS      = 9,
  parameter int MOVE_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES = 100_000_000,
  parameter int IDLE_CYCLES = 250_000_000
) (
  input  logic              clk,
  input  logic              res,
  input  logic [FLOORS-1:0] sw,
  output logic [3:0]        LED_RED,
  output logic [3:0]        LED_GREEN,
  output logic [3:0]        floor,
  output logic [3:0]        next_floor,
  output logic [1:0]        dir,
  output logic [FLOORS-1:0] pending
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MOVE = 2'b01,
    ST_DOOR = 2'b10
  } state_t;

  localparam logic [31:0] MOVE_LOAD = 32'(MOVE_CYCLES - 1);
  localparam logic [31:0] DOOR_LOAD = 32'(DOOR_CYCLES - 1);
  localparam logic [3:0]  TOP_FLOOR = 4'(FLOORS - 1);

  state_t            state_r, state_n;
  logic [3:0]        floor_r, floor_n;
  logic [FLOORS-1:0] pending_r, pend_n;
  logic              pref_r, pref_n;   // 1 = up preferred, 0 = down
  logic [31:0]       timer_r, timer_n;
  logic [FLOORS-1:0] sw_q_r;
  logic [FLOORS-1:0] rise_s;
  logic [3:0]        step_s;
  logic              at_limit_s;

  // True when any request lies strictly beyond floor f in the given direction.
  function automatic logic any_beyond(input logic [FLOORS-1:0] p,
                                      input logic [3:0] f,
                                      input logic up);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (p[i] && (up ? (i > int'(f)) : (i < int'(f)))) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  // Nearest request strictly beyond floor f in the given direction, 4'hF if none.
  function automatic logic [3:0] nearest_req(input logic [FLOORS-1:0] p,
                                             input logic [3:0] f,
                                             input logic up);
    logic [3:0] r;
    r = 4'hF;
    if (up) begin
      for (int i = FLOORS - 1; i >= 0; i--) begin
        if (p[i] && (i > int'(f))) begin
          r = 4'(i);
        end else begin
          r = r;
        end
      end
    end else begin
      for (int i = 0; i < FLOORS; i++) begin
        if (p[i] && (i < int'(f))) begin
          r = 4'(i);
        end else begin
          r = r;
        end
      end
    end
    return r;
  endfunction

  assign rise_s     = sw & ~sw_q_r;
  assign step_s     = pref_r ? (floor_r + 4'd1) : (floor_r - 4'd1);
  assign at_limit_s = pref_r ? (floor_r == TOP_FLOOR) : (floor_r == 4'd0);

`ifdef LIFT_IDLE_RETURN_EN
  logic [31:0] idle_cnt_r, idle_cnt_n;
  logic        idle_run_s;
  assign idle_run_s = (state_r == ST_IDLE) && (pending_r == '0) && (floor_r != 4'd0);
`else
  logic unused_idle_s;
  assign unused_idle_s = ^(32'(IDLE_CYCLES));
`endif

  // Next-state logic: request capture, SCAN decisions, floor stepping and timers.
  always_comb begin
    state_n = state_r;
    floor_n = floor_r;
    pref_n  = pref_r;
    timer_n = timer_r;
    pend_n  = pending_r | rise_s;
`ifdef LIFT_IDLE_RETURN_EN
    idle_cnt_n = 32'd0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (pending_r[floor_r]) begin
          pend_n[floor_r] = 1'b0;
          state_n         = ST_DOOR;
          timer_n         = DOOR_LOAD;
        end else if (any_beyond(pending_r, floor_r, pref_r)) begin
          state_n = ST_MOVE;
          timer_n = MOVE_LOAD;
        end else if (any_beyond(pending_r, floor_r, ~pref_r)) begin
          pref_n  = ~pref_r;
          state_n = ST_MOVE;
          timer_n = MOVE_LOAD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_MOVE: begin
        if (timer_r != 32'd0) begin
          timer_n = timer_r - 32'd1;
        end else if (at_limit_s) begin
          // Never step past the shaft ends; park instead.
          state_n = ST_IDLE;
        end else begin
          floor_n = step_s;
          // pend_n already holds same-cycle rises, so an arrival serves them once.
          if (pend_n[step_s]) begin
            pend_n[step_s] = 1'b0;
            state_n        = ST_DOOR;
            timer_n        = DOOR_LOAD;
          end else if (any_beyond(pend_n, step_s, pref_r)) begin
            timer_n = MOVE_LOAD;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_DOOR: begin
        if (rise_s[floor_r]) begin
          // Pressing the open floor's button keeps the doors open instead of queuing.
          pend_n[floor_r] = pending_r[floor_r];
          timer_n         = DOOR_LOAD;
        end else if (timer_r == 32'd0) begin
          state_n = ST_IDLE;
        end else begin
          timer_n = timer_r - 32'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        timer_n = 32'd0;
      end
    endcase
`ifdef LIFT_IDLE_RETURN_EN
    if (idle_run_s) begin
      if (idle_cnt_r == 32'(IDLE_CYCLES - 1)) begin
        pend_n[0]  = 1'b1;
        idle_cnt_n = 32'd0;
      end else begin
        idle_cnt_n = idle_cnt_r + 32'd1;
      end
    end else begin
      idle_cnt_n = 32'd0;
    end
`endif
  end

  // State, timer, request set and all registered outputs.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_r    <= ST_IDLE;
      floor_r    <= 4'd0;
      pending_r  <= '0;
      pref_r     <= 1'b1;
      timer_r    <= 32'd0;
      sw_q_r     <= '0;
      LED_RED    <= 4'hF;
      LED_GREEN  <= 4'h0;
      next_floor <= 4'hF;
      dir        <= 2'b00;
    end else begin
      state_r    <= state_n;
      floor_r    <= floor_n;
      pending_r  <= pend_n;
      pref_r     <= pref_n;
      timer_r    <= timer_n;
      sw_q_r     <= sw;
      LED_RED    <= (state_n == ST_DOOR) ? 4'h0 : 4'hF;
      LED_GREEN  <= (state_n == ST_DOOR) ? 4'hF : 4'h0;
      next_floor <= (state_n == ST_MOVE) ? nearest_req(pend_n, floor_n, pref_n) : 4'hF;
      dir        <= (state_n == ST_MOVE) ? (pref_n ? 2'b01 : 2'b10) : 2'b00;
    end
  end

`ifdef LIFT_IDLE_RETURN_EN
  // Idle-away-from-ground counter for the automatic return to floor 0.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      idle_cnt_r <= 32'd0;
    end else begin
      idle_cnt_r <= idle_cnt_n;
    end
  end
`endif

  assign floor   = floor_r;
  assign pending = pending_r;

endmodule

// File: tb/tb_lift_scheduler.sv
// Self-checking bench for lift_scheduler (FLOORS=9, MOVE=4, DOOR=3, IDLE=10).
// Expected door-stop floors are queued as requests are made and popped when
// the doors open; timing and reset behaviour are checked directly.
module tb_lift_scheduler;

  logic       clk;
  logic       res;
  logic [8:0] sw;
  logic [3:0] LED_RED, LED_GREEN, floor, next_floor;
  logic [1:0] dir;
  logic [8:0] pending;

  int n_checks = 0;
  int n_errors = 0;
  int door_count = 0;
  logic prev_green = 1'b0;
  int exp_q[$];

  lift_scheduler #(
    .FLOORS(9), .MOVE_CYCLES(4), .DOOR_CYCLES(3), .IDLE_CYCLES(10)
  ) dut (
    .clk(clk), .res(res), .sw(sw),
    .LED_RED(LED_RED), .LED_GREEN(LED_GREEN),
    .floor(floor), .next_floor(next_floor), .dir(dir), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_door(input logic [3:0] f, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (LED_GREEN == 4'hF && floor == f) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_floor"}, 32'(floor), 32'd0);
    check_val({tag, "_pend"}, 32'(pending), 32'd0);
    check_val({tag, "_dir"}, 32'(dir), 32'd0);
    check_val({tag, "_red"}, 32'(LED_RED), 32'hF);
    check_val({tag, "_green"}, 32'(LED_GREEN), 32'h0);
    check_val({tag, "_next"}, 32'(next_floor), 32'hF);
  endtask

  // Door-open monitor: each new opening pops the expected stop floor.
  always @(negedge clk) begin
    if (res && LED_GREEN == 4'hF && !prev_green) begin
      door_count <= door_count + 1;
      check_val("door_red_off", 32'(LED_RED), 32'h0);
      if (exp_q.size() == 0) check_val("door_unexpected", 32'(floor), 32'hFF);
      else check_val("door_floor", 32'(floor), 32'(exp_q.pop_front()));
    end
    prev_green <= (LED_GREEN == 4'hF);
  end

  initial begin
    logic ok;
    logic saw_down;
    int   base;
    res = 1'b0;
    sw  = 9'h000;
    step(2);
    check_reset_vals("rst");
    res = 1'b1;
    step(1);

    // Test 1: single request to floor 3 from ground.
    sw[3] = 1'b1;
    exp_q.push_back(3);
    step(1);
    check_val("t1_pend", 32'(pending), 32'h008);
    check_val("t1_dir_idle", 32'(dir), 32'd0);
    step(1);
    check_val("t1_dir_up", 32'(dir), 32'd1);
    check_val("t1_next", 32'(next_floor), 32'd3);
    step(3);
    check_val("t1_floor0", 32'(floor), 32'd0);
    step(1);
    check_val("t1_floor1", 32'(floor), 32'd1);
    step(4);
    check_val("t1_floor2", 32'(floor), 32'd2);
    step(4);
    check_val("t1_floor3", 32'(floor), 32'd3);
    check_val("t1_green", 32'(LED_GREEN), 32'hF);
    check_val("t1_pend_clr", 32'(pending), 32'h000);
    check_val("t1_dir_door", 32'(dir), 32'd0);
    step(2);
    check_val("t1_green_last", 32'(LED_GREEN), 32'hF);
    step(1);
    check_val("t1_red", 32'(LED_RED), 32'hF);
    check_val("t1_dir_stop", 32'(dir), 32'd0);
    check_val("t1_held_norereq", 32'(pending), 32'h000);

    // Test 2: heading to 7 from 3, add 5 and 1: stops 5, 7, then reverse to 1.
    sw = 9'h080;
    step(1);
    check_val("t2_pend7", 32'(pending), 32'h080);
    step(1);
    check_val("t2_dir_up", 32'(dir), 32'd1);
    check_val("t2_next7", 32'(next_floor), 32'd7);
    sw = 9'h022;
    exp_q.push_back(5);
    exp_q.push_back(7);
    exp_q.push_back(1);
    step(1);
    check_val("t2_pend", 32'(pending), 32'h0A2);
    check_val("t2_next5", 32'(next_floor), 32'd5);
    sw = 9'h000;
    base = door_count;
    saw_down = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (door_count >= base + 3 && LED_RED == 4'hF) begin
        ok = 1'b1;
        break;
      end
      if (dir == 2'b10) saw_down = 1'b1;
      step(1);
    end
    check_val("t2_timeout", 32'(ok), 32'd1);
    check_val("t2_reversed", 32'(saw_down), 32'd1);
    check_val("t2_floor", 32'(floor), 32'd1);
    check_val("t2_pend_end", 32'(pending), 32'h000);

    // Test 3: re-press at an open door extends it, without queuing.
    sw[5] = 1'b1;
    exp_q.push_back(5);
    step(1);
    sw[5] = 1'b0;
    wait_door(4'd5, 200, ok);
    check_val("t3_timeout", 32'(ok), 32'd1);
    step(1);
    sw[5] = 1'b1;
    step(1);
    check_val("t3_green_rise", 32'(LED_GREEN), 32'hF);
    check_val("t3_pend5", 32'(pending[5]), 32'd0);
    step(1);
    check_val("t3_green_ext1", 32'(LED_GREEN), 32'hF);
    step(1);
    check_val("t3_green_ext2", 32'(LED_GREEN), 32'hF);
    step(1);
    check_val("t3_red", 32'(LED_RED), 32'hF);
    check_val("t3_pend_end", 32'(pending), 32'h000);
    sw[5] = 1'b0;

    // Test 4: asynchronous reset while moving down between floors 3 and 2.
    sw[0] = 1'b1;
    step(1);
    sw[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (floor == 4'd3 && dir == 2'b10) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    check_val("t4_timeout", 32'(ok), 32'd1);
    step(1);
    res = 1'b0;
    #1;
    check_reset_vals("t4_async");
    step(1);
    res = 1'b1;
    step(10);
    check_val("t4_idle_floor", 32'(floor), 32'd0);
    check_val("t4_idle_dir", 32'(dir), 32'd0);
    check_val("t4_idle_pend", 32'(pending), 32'h000);

    // Test 5: switch held high through reset release opens doors at ground.
    res = 1'b0;
    sw  = 9'h001;
    step(2);
    res = 1'b1;
    exp_q.push_back(0);
    step(1);
    check_val("t5_pend", 32'(pending), 32'h001);
    check_val("t5_green_pre", 32'(LED_GREEN), 32'h0);
    step(1);
    check_val("t5_green", 32'(LED_GREEN), 32'hF);
    check_val("t5_floor", 32'(floor), 32'd0);
    check_val("t5_dir", 32'(dir), 32'd0);
    step(3);
    check_val("t5_red", 32'(LED_RED), 32'hF);
    sw = 9'h000;

    // Test 6: park at floor 4; idle return only with the optional feature.
    sw[4] = 1'b1;
    exp_q.push_back(4);
    step(1);
    sw[4] = 1'b0;
    wait_door(4'd4, 200, ok);
    check_val("t6_timeout", 32'(ok), 32'd1);
    step(3);
    check_val("t6_red", 32'(LED_RED), 32'hF);
`ifdef LIFT_IDLE_RETURN_EN
    exp_q.push_back(0);
    wait_door(4'd0, 300, ok);
    check_val("t6_return", 32'(ok), 32'd1);
`else
    step(30);
    check_val("t6_parked_floor", 32'(floor), 32'd4);
    check_val("t6_parked_dir", 32'(dir), 32'd0);
    check_val("t6_parked_pend", 32'(pending), 32'h000);
`endif
    step(2);
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
